line_buffer_3x3: RTL and testbench

LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

---
 rtl/line_buffer_3x3.sv | 274 +++++++++++++++++++++++++++
 tb/tb_line_buffer_3x3.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3x3.sv
// ---------------------------------------------------------------------------
// LineBuffer3x3 (module line_buffer_3x3)
//
// Purpose:
//   Streams a raster-order 24-bit RGB image and produces one 3x3 pixel
//   window per image pixel, in raster order of the window centre. Two line
//   buffers hold the previous two rows; a two-column shift register plus the
//   freshly read column form the raw window. Positions outside the image are
//   zero-padded, or edge-replicated when LINE_BUFFER_BORDER_REPLICATE_EN is
//   defined.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  synchronous active-high reset
//   input_valid          input_pixel is valid this cycle
//   input_pixel[23:0]    raster-order pixel {R,G,B}
//   input_ready          pixel accepted when input_valid && input_ready
//   output_pixel_1..9    3x3 window, row-major, 1 = top-left, 5 = centre
//   output_valid         window outputs valid this cycle
//   frame_done           one-cycle pulse after the last window of a frame
//
// Configuration macro:
//   LINE_BUFFER_BORDER_REPLICATE_EN  defined = edge replication,
//                                    undefined = zero padding
// ---------------------------------------------------------------------------
module line_buffer_3x3 #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_valid,
    input  logic [23:0] input_pixel,
    output logic        input_ready,
    output logic [23:0] output_pixel_1,
    output logic [23:0] output_pixel_2,
    output logic [23:0] output_pixel_3,
    output logic [23:0] output_pixel_4,
    output logic [23:0] output_pixel_5,
    output logic [23:0] output_pixel_6,
    output logic [23:0] output_pixel_7,
    output logic [23:0] output_pixel_8,
    output logic [23:0] output_pixel_9,
    output logic        output_valid,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] colCnt_q, colCnt_d;
    logic [RW-1:0] rowCnt_q, rowCnt_d;
    logic [CW-1:0] cenCol_q, cenCol_d;
    logic [RW-1:0] cenRow_q, cenRow_d;
    logic          outValid_q;
    logic          frameDone_q;

    // lineA holds the most recent row per column, lineB the row before it.
    logic [23:0] lineA [IMG_WIDTH];
    logic [23:0] lineB [IMG_WIDTH];

    // Two older window columns; index 0 is the leftmost.
    logic [23:0] shTop_q [2];
    logic [23:0] shMid_q [2];
    logic [23:0] shBot_q [2];

    logic [23:0] winPix_q [9];
    logic [23:0] winPix_d [9];
    logic [23:0] raw [3][3];

    logic        accept;
    logic        step;
    logic        emit;
    logic [23:0] newTop;
    logic [23:0] newMid;
    logic [23:0] newBot;
    logic        topOut;
    logic        botOut;
    logic        leftOut;
    logic        rightOut;

    // A "step" feeds one column through the line buffers. During FLUSH the
    // block keeps stepping with a virtual all-zero row below the image so the
    // last row of windows drains without new input; every pixel of that
    // virtual row lands in a masked window position.
    assign accept = input_valid && input_ready;
    assign step   = accept || (state_q == FLUSH);
    assign emit   = (accept && (state_q == RUN)) || (state_q == FLUSH);
    assign newTop = lineB[colCnt_q];
    assign newMid = lineA[colCnt_q];
    assign newBot = (state_q == FLUSH) ? 24'h000000 : input_pixel;

    // Border flags come from the centre position only, so any stale data from
    // a previous row, a previous frame or an aborted frame is always masked.
    assign topOut   = (cenRow_q == '0);
    assign botOut   = (cenRow_q == LAST_ROW);
    assign leftOut  = (cenCol_q == '0);
    assign rightOut = (cenCol_q == LAST_COL);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. FILL ends once the first pixel of row 1 is in, since
    // the next accepted pixel completes the first window. FLUSH ends when the
    // bottom-right window is being emitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:  if (accept && (rowCnt_q == ROW_ONE) && (colCnt_q == '0)) state_d = RUN;
            RUN:   if (accept && (rowCnt_q == LAST_ROW) && (colCnt_q == LAST_COL)) state_d = FLUSH;
            FLUSH: if ((cenRow_q == LAST_ROW) && (cenCol_q == LAST_COL)) state_d = DONE;
            DONE:  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Output logic. Ready is forced low in the reset cycle itself.
    always_comb begin
        input_ready = !rst && ((state_q == FILL) || (state_q == RUN));
    end

    // Feed counters advance per step; the row does not advance while
    // flushing because the virtual row only exists to drain windows.
    // Centre counters advance per emitted window and wrap to 0 at frame end.
    always_comb begin
        colCnt_d = colCnt_q;
        rowCnt_d = rowCnt_q;
        cenCol_d = cenCol_q;
        cenRow_d = cenRow_q;
        if (state_q == DONE) begin
            colCnt_d = '0;
            rowCnt_d = '0;
            cenCol_d = '0;
            cenRow_d = '0;
        end else begin
            if (step) begin
                if (colCnt_q == LAST_COL) begin
                    colCnt_d = '0;
                    if (state_q != FLUSH) begin
                        rowCnt_d = (rowCnt_q == LAST_ROW) ? '0 : rowCnt_q + ROW_ONE;
                    end
                end else begin
                    colCnt_d = colCnt_q + COL_ONE;
                end
            end
            if (emit) begin
                if (cenCol_q == LAST_COL) begin
                    cenCol_d = '0;
                    cenRow_d = (cenRow_q == LAST_ROW) ? '0 : cenRow_q + ROW_ONE;
                end else begin
                    cenCol_d = cenCol_q + COL_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colCnt_q <= '0;
            rowCnt_q <= '0;
            cenCol_q <= '0;
            cenRow_q <= '0;
        end else begin
            colCnt_q <= colCnt_d;
            rowCnt_q <= rowCnt_d;
            cenCol_q <= cenCol_d;
            cenRow_q <= cenRow_d;
        end
    end

    // Line buffer RAMs: one read (combinational, above) and one write per
    // step. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (step) begin
            lineA[colCnt_q] <= newBot;
            lineB[colCnt_q] <= newMid;
        end
    end

    // Column shift register; needs no reset because the border masks cover
    // every position that could hold stale data.
    always_ff @(posedge clk) begin
        if (step) begin
            shTop_q[0] <= shTop_q[1];
            shMid_q[0] <= shMid_q[1];
            shBot_q[0] <= shBot_q[1];
            shTop_q[1] <= newTop;
            shMid_q[1] <= newMid;
            shBot_q[1] <= newBot;
        end
    end

    // Raw window: two stored columns plus the column being read this cycle.
    always_comb begin
        raw[0][0] = shTop_q[0];
        raw[0][1] = shTop_q[1];
        raw[0][2] = newTop;
        raw[1][0] = shMid_q[0];
        raw[1][1] = shMid_q[1];
        raw[1][2] = newMid;
        raw[2][0] = shBot_q[0];
        raw[2][1] = shBot_q[1];
        raw[2][2] = newBot;
    end

    // Border handling. Replication redirects an outside row/column to the
    // centre row/column, which is the nearest in-image one; corners fall out
    // of applying both redirections.
    always_comb begin
        logic [1:0] sr;
        logic [1:0] sc;
        logic       outPos;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
                outPos = 1'b0;
                sr = (((i == 0) && topOut) || ((i == 2) && botOut)) ? 2'd1 : 2'(i);
                sc = (((j == 0) && leftOut) || ((j == 2) && rightOut)) ? 2'd1 : 2'(j);
`else
                outPos = ((i == 0) && topOut) || ((i == 2) && botOut) ||
                         ((j == 0) && leftOut) || ((j == 2) && rightOut);
                sr = 2'(i);
                sc = 2'(j);
`endif
                winPix_d[i * 3 + j] = outPos ? 24'h000000 : raw[sr][sc];
            end
        end
    end

    // Registered window outputs hold their value whenever nothing is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                winPix_q[k] <= 24'h000000;
            end
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            if (emit) begin
                for (int k = 0; k < 9; k++) begin
                    winPix_q[k] <= winPix_d[k];
                end
            end
            outValid_q  <= emit;
            frameDone_q <= (state_q == DONE);
        end
    end

    assign output_pixel_1 = winPix_q[0];
    assign output_pixel_2 = winPix_q[1];
    assign output_pixel_3 = winPix_q[2];
    assign output_pixel_4 = winPix_q[3];
    assign output_pixel_5 = winPix_q[4];
    assign output_pixel_6 = winPix_q[5];
    assign output_pixel_7 = winPix_q[6];
    assign output_pixel_8 = winPix_q[7];
    assign output_pixel_9 = winPix_q[8];
    assign output_valid   = outValid_q;
    assign frame_done     = frameDone_q;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// ---------------------------------------------------------------------------
// Testbench for line_buffer_3x3 on a 4x4 image. Expected windows come from an
// index-based 3x3 reference model over the stimulus image and are queued when
// a frame is driven; a negedge monitor pops and compares every emitted window
// and logs accept/valid/done cycles for the per-scenario timing checks.
// ---------------------------------------------------------------------------
module tb_line_buffer_3x3;

   localparam int W = 4;
   localparam int H = 4;
   localparam int P = W * H;

   logic        clk = 1'b0;
   logic        rst;
   logic        input_valid;
   logic [23:0] input_pixel;
   logic        input_ready;
   logic [23:0] op1, op2, op3, op4, op5, op6, op7, op8, op9;
   logic        output_valid;
   logic        frame_done;
   logic [215:0] obsVec;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int validLog[$];
   int acceptLog[$];
   int doneLog[$];
   logic [215:0] expQ[$];
   logic [215:0] firstWin;
   logic [215:0] lastWin;
   logic [23:0]  img [P];

   line_buffer_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .input_valid(input_valid), .input_pixel(input_pixel),
      .input_ready(input_ready),
      .output_pixel_1(op1), .output_pixel_2(op2), .output_pixel_3(op3),
      .output_pixel_4(op4), .output_pixel_5(op5), .output_pixel_6(op6),
      .output_pixel_7(op7), .output_pixel_8(op8), .output_pixel_9(op9),
      .output_valid(output_valid), .frame_done(frame_done)
   );

   assign obsVec = {op9, op8, op7, op6, op5, op4, op3, op2, op1};

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference window for centre (r,c); element k sits at bits [k*24 +: 24].
   function automatic logic [215:0] refWindow(input int r, input int c);
      logic [215:0] v;
      int rr;
      int cc;
      v = '0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            rr = r + dr - 1;
            cc = c + dc - 1;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
            if (rr < 0) rr = 0;
            if (rr > H - 1) rr = H - 1;
            if (cc < 0) cc = 0;
            if (cc > W - 1) cc = W - 1;
            v[(dr * 3 + dc) * 24 +: 24] = img[rr * W + cc];
`else
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
               v[(dr * 3 + dc) * 24 +: 24] = img[rr * W + cc];
`endif
         end
      end
      return v;
   endfunction

   // Monitor: samples away from the active edge, logs events and pops the
   // scoreboard for every emitted window.
   always @(negedge clk) begin
      logic [215:0] expWin;
      cyc++;
      if (input_valid && input_ready) acceptLog.push_back(cyc);
      if (frame_done) doneLog.push_back(cyc);
      if (output_valid) begin
         validLog.push_back(cyc);
         if (validLog.size() == 1) firstWin = obsVec;
         lastWin = obsVec;
         vectors++;
         if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL window_unexpected cyc=%0d got=%h required=no window", cyc, obsVec);
         end else begin
            expWin = expQ.pop_front();
            if (obsVec !== expWin) begin
               miscompares++;
               $display("[TB] FAIL window_data cyc=%0d got=%h required=%h", cyc, obsVec, expWin);
            end
         end
      end
   end

   // Global safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout got=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearLogs();
      validLog.delete();
      acceptLog.delete();
      doneLog.delete();
   endtask

   task automatic indexImage();
      for (int n = 0; n < P; n++) img[n] = 24'(n);
   endtask

   // Drives nPix pixels of img with gap idle cycles before each one, queuing
   // the windows those pixels complete. Afterwards input_valid is left at
   // junk with value FFFFFF (offered while the block drains).
   task automatic applyStimulus(input int nPix, input int gap, input bit junk);
      int nExp;
      nExp = (nPix == P) ? P : nPix - W - 1;
      for (int k = 0; k < nExp; k++) expQ.push_back(refWindow(k / W, k % W));
      for (int n = 0; n < nPix; n++) begin
         for (int g = 0; g < gap; g++) begin
            input_valid = 1'b0;
            @(posedge clk); #1;
         end
         input_valid = 1'b1;
         input_pixel = img[n];
         @(posedge clk); #1;
      end
      input_valid = junk;
      input_pixel = 24'hFFFFFF;
   endtask

   // Bounded wait for frame_done; junk is withdrawn once all windows are out,
   // which is before the block becomes ready again.
   task automatic waitFrameDone();
      int t;
      t = 0;
      while (doneLog.size() == 0 && t < 60) begin
         if (validLog.size() >= P) input_valid = 1'b0;
         @(posedge clk); #1;
         t++;
      end
      input_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clearLogs();
      rst = 1'b1;
      input_valid = 1'b1;
      input_pixel = 24'h123456;
      @(negedge clk);
      vectors++;
      if (input_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ready_during_rst got=%b required=0", input_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      input_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (input_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready_after got=%b required=1", input_ready);
      end
      vectors++;
      if (output_valid !== 1'b0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags got=%b%b required=00", output_valid, frame_done);
      end
      vectors++;
      if (obsVec !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_window got=%h required=0", obsVec);
      end
      vectors++;
      if (acceptLog.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL reset_no_accept got=%0d required=0", acceptLog.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [215:0] expFirst;
      logic [215:0] expLast;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
      expFirst = {24'd5, 24'd4, 24'd4, 24'd1, 24'd0, 24'd0, 24'd1, 24'd0, 24'd0};
      expLast  = {24'd15, 24'd15, 24'd14, 24'd15, 24'd15, 24'd14, 24'd11, 24'd11, 24'd10};
`else
      expFirst = {24'd5, 24'd4, 24'd0, 24'd1, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
      expLast  = {24'd0, 24'd0, 24'd0, 24'd0, 24'd15, 24'd14, 24'd0, 24'd11, 24'd10};
`endif
      clearLogs();
      indexImage();
      applyStimulus(P, 0, 1'b0);
      waitFrameDone();
      vectors++;
      if (validLog.size() != P) begin
         miscompares++;
         $display("[TB] FAIL basic_window_count got=%0d required=%0d", validLog.size(), P);
      end
      vectors++;
      if (validLog.size() < 1 || acceptLog.size() < 6 || validLog[0] != acceptLog[5] + 1) begin
         miscompares++;
         $display("[TB] FAIL basic_first_valid_cycle got=%0d required=%0d",
                  validLog.size() > 0 ? validLog[0] : -1, acceptLog.size() > 5 ? acceptLog[5] + 1 : -1);
      end
      vectors++;
      if (firstWin !== expFirst) begin
         miscompares++;
         $display("[TB] FAIL basic_first_window got=%h required=%h", firstWin, expFirst);
      end
      vectors++;
      if (lastWin !== expLast) begin
         miscompares++;
         $display("[TB] FAIL basic_last_window got=%h required=%h", lastWin, expLast);
      end
      vectors++;
      if (doneLog.size() != 1 || validLog.size() != P || doneLog[0] != validLog[P-1] + 1) begin
         miscompares++;
         $display("[TB] FAIL basic_frame_done got=%0d pulses required=1 pulse after last window",
                  doneLog.size());
      end
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL basic_scoreboard_left got=%0d required=0", expQ.size());
      end
   endtask

   task automatic test_gaps();
      int bad;
      clearLogs();
      indexImage();
      applyStimulus(P, 1, 1'b0);
      waitFrameDone();
      vectors++;
      if (validLog.size() != P) begin
         miscompares++;
         $display("[TB] FAIL gaps_window_count got=%0d required=%0d", validLog.size(), P);
      end
      bad = 0;
      if (validLog.size() == P && acceptLog.size() == P) begin
         for (int k = 0; k < P - W - 1; k++)
            if (validLog[k] != acceptLog[k + W + 1] + 1) bad++;
      end else begin
         bad = -1;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("[TB] FAIL gaps_valid_follows_accept got=%0d bad required=0", bad);
      end
      vectors++;
      if (validLog.size() != P || validLog[P-1] - validLog[P-W-2] != W + 1) begin
         miscompares++;
         $display("[TB] FAIL gaps_flush_back_to_back got=%0d required=%0d",
                  validLog.size() == P ? validLog[P-1] - validLog[P-W-2] : -1, W + 1);
      end
      vectors++;
      if (doneLog.size() != 1) begin
         miscompares++;
         $display("[TB] FAIL gaps_frame_done got=%0d required=1", doneLog.size());
      end
   endtask

   task automatic test_flush_ignore();
      clearLogs();
      indexImage();
      applyStimulus(P, 0, 1'b1);
      waitFrameDone();
      vectors++;
      if (acceptLog.size() != P) begin
         miscompares++;
         $display("[TB] FAIL flush_junk_ignored got=%0d accepts required=%0d", acceptLog.size(), P);
      end
      vectors++;
      if (doneLog.size() != 1) begin
         miscompares++;
         $display("[TB] FAIL flush_frame_done got=%0d required=1", doneLog.size());
      end
      clearLogs();
      applyStimulus(P, 0, 1'b0);
      waitFrameDone();
      vectors++;
      if (validLog.size() != P || expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL flush_second_frame got=%0d windows required=%0d", validLog.size(), P);
      end
      vectors++;
      if (validLog.size() < 1 || acceptLog.size() < 6 || validLog[0] != acceptLog[5] + 1) begin
         miscompares++;
         $display("[TB] FAIL flush_second_first_valid got=%0d required=accept5+1",
                  validLog.size() > 0 ? validLog[0] : -1);
      end
   endtask

   task automatic test_reset_midframe();
      clearLogs();
      indexImage();
      applyStimulus(9, 0, 1'b0);
      rst = 1'b1;
      input_valid = 1'b1;
      input_pixel = 24'hFFFFFF;
      @(posedge clk); #1;
      rst = 1'b0;
      input_valid = 1'b0;
      vectors++;
      if (validLog.size() != 4 || expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_partial got=%0d windows required=4", validLog.size());
      end
      clearLogs();
      applyStimulus(P, 0, 1'b0);
      waitFrameDone();
      vectors++;
      if (validLog.size() != P || expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_frame got=%0d windows required=%0d", validLog.size(), P);
      end
      vectors++;
      if (validLog.size() < 1 || acceptLog.size() < 6 || validLog[0] != acceptLog[5] + 1) begin
         miscompares++;
         $display("[TB] FAIL midreset_first_valid got=%0d required=accept5+1",
                  validLog.size() > 0 ? validLog[0] : -1);
      end
      vectors++;
      if (doneLog.size() != 1) begin
         miscompares++;
         $display("[TB] FAIL midreset_frame_done got=%0d required=1", doneLog.size());
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         clearLogs();
         for (int n = 0; n < P; n++) img[n] = 24'($urandom);
         applyStimulus(P, f, f[0]);
         waitFrameDone();
         vectors++;
         if (validLog.size() != P || doneLog.size() != 1 || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL random_frame%0d got=%0d windows %0d done required=%0d windows 1 done",
                     f, validLog.size(), doneLog.size(), P);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      input_valid = 1'b0;
      input_pixel = 24'h0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_gaps();
      test_flush_ignore();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
